// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential divider.
// Exports the state enum, width defaults and counter width.
package div_pkg;

  localparam int DEF_WIDTH_N = 8;
  localparam int DEF_WIDTH_D = 4;
  localparam int DEF_CNT_W   = $clog2(DEF_WIDTH_N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift, trial subtract, restore.
// In: pr, bin, divisor. Out: pr_nxt, qbit.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH_D = DEF_WIDTH_D
) (
  input  logic [WIDTH_D:0]   pr,
  input  logic               bin,
  input  logic [WIDTH_D-1:0] divisor,
  output logic [WIDTH_D:0]   pr_nxt,
  output logic               qbit
);

  logic [WIDTH_D+1:0] sh;
  logic [WIDTH_D+1:0] dv;

  assign sh   = {pr, bin};
  assign dv   = (WIDTH_D+2)'(divisor);
  assign qbit = (sh >= dv);

  // pr < divisor before the shift, so the result fits in pr's width
  assign pr_nxt = qbit ? (WIDTH_D+1)'(sh - dv)
                       : sh[WIDTH_D:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock.
// Ports: clk, rst, start, dividend, divisor -> busy, done,
// quotient, remainder, div_by_zero (all registered).
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH_N = DEF_WIDTH_N,
  parameter int WIDTH_D = DEF_WIDTH_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               div_by_zero
);

  localparam int CW = $clog2(WIDTH_N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH_N - 1);

  div_state_t         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH_N-1:0] nreg;
  logic [WIDTH_N-1:0] qreg;
  logic [WIDTH_D-1:0] dreg;
  logic [WIDTH_D:0]   pr;
  logic [WIDTH_D:0]   pr_nxt;
  logic               qbit;
  logic [WIDTH_N-1:0] q_nxt;

  div_step #(
    .WIDTH_D (WIDTH_D)
  ) u_step (
    .pr      (pr),
    .bin     (nreg[WIDTH_N-1]),
    .divisor (dreg),
    .pr_nxt  (pr_nxt),
    .qbit    (qbit)
  );

  assign q_nxt = {qreg[WIDTH_N-2:0], qbit};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      nreg        <= '0;
      qreg        <= '0;
      dreg        <= '0;
      pr          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend[WIDTH_D-1:0];
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              nreg        <= dividend;
              dreg        <= divisor;
              pr          <= '0;
              qreg        <= '0;
              cnt         <= '0;
              div_by_zero <= 1'b0;
              state       <= RUN;
            end
          end
        end
        RUN: begin
          nreg <= nreg << 1;
          pr   <= pr_nxt;
          qreg <= q_nxt;
          cnt  <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            quotient  <= q_nxt;
            remainder <= pr_nxt[WIDTH_D-1:0];
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider.
// Compares against plain / and % with latency checks.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int errs = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  seq_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // Caller must be positioned at a negedge.
  // poke>0 pulses start with other operands
  // at that cycle of the operation.
  task automatic run_op(input int n,
                        input int d,
                        input int poke);
    int eq, er, ez, elat;
    int lat, nbusy;
    bit got;
    if (d == 0) begin
      eq = 255; er = n % 16; ez = 1; elat = 1;
    end else begin
      eq = n / d; er = n % d; ez = 0; elat = 9;
    end
    dividend = 8'(n);
    divisor  = 4'(d);
    start    = 1'b1;
    got = 0; lat = 0; nbusy = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      start = (poke != 0 && i == poke);
      if (poke != 0 && i == poke) begin
        dividend = 8'd50;
        divisor  = 4'd3;
      end
      if (busy) nbusy++;
      if (done) begin
        got = 1;
        lat = i;
        chk("quot", int'(quotient), eq);
        chk("rem", int'(remainder), er);
        chk("dbz", int'(div_by_zero), ez);
      end
    end
    start = 1'b0;
    chk("timeout", int'(got), 1);
    chk("latency", lat, elat);
    chk("busy_len", nbusy, elat);
    @(negedge clk);
    chk("done_pulse", int'(done), 0);
    chk("busy_fall", int'(busy), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_q", int'(quotient), 0);
    chk("rst_r", int'(remainder), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(143, 11, 0);
    run_op(100, 7, 0);
    run_op(255, 1, 0);
    run_op(255, 15, 0);
    run_op(7, 9, 0);
    run_op(0, 5, 0);
    run_op(200, 0, 0);
    run_op(143, 11, 3);
    run_op(50, 3, 0);

    // abort mid-run with reset
    dividend = 8'd255;
    divisor  = 4'd15;
    start    = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_q", int'(quotient), 0);
    chk("abort_r", int'(remainder), 0);
    chk("abort_dbz", int'(div_by_zero), 0);
    rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done) seen++;
      end
      chk("abort_nodone", seen, 0);
    end
    run_op(143, 11, 0);

    for (int k = 0; k < 300; k++) begin
      run_op(int'($urandom_range(0, 255)),
             int'($urandom_range(0, 15)), 0);
    end

    $display("Result: errors=%0d of %0d checks",
             errs, nchk);
    $finish;
  end

endmodule
